// File: rtl/gbc_snd_reg_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gbc_snd_reg_player
// Brief    : Replays a script of sound-register writes, reads and ce-timed waits
//            onto the s1_* CPU-side register port.
// Revision : 1.0
// ============================================================================
module gbc_snd_reg_player #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] script_addr,
    input  logic [15:0]       script_data,
    output logic              s1_read,
    output logic              s1_write,
    output logic [6:0]        s1_addr,
    output logic [7:0]        s1_writedata,
    input  logic [7:0]        s1_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        last_read
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_WRITE   = 3'd3,
        S_READ    = 3'd4,
        S_WAIT    = 3'd5,
        S_ADVANCE = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] c_PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [2:0]        c_OP_WAIT  = 3'b000;
    localparam logic [2:0]        c_OP_END   = 3'b001;
    localparam logic [2:0]        c_OP_READ  = 3'b010;
    localparam logic [2:0]        c_OP_LOOP  = 3'b011;

    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_ptr, w_ptr_n;
    logic [11:0]       r_cnt, w_cnt_n;
    logic              r_read, w_read_n;
    logic              r_write, w_write_n;
    logic [6:0]        r_addr, w_addr_n;
    logic [7:0]        r_wdata, w_wdata_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              r_error, w_error_n;
    logic [7:0]        r_last_read, w_last_read_n;

    always_comb begin
        w_state_n     = r_state;
        w_ptr_n       = r_ptr;
        w_cnt_n       = r_cnt;
        w_read_n      = r_read;
        w_write_n     = r_write;
        w_addr_n      = r_addr;
        w_wdata_n     = r_wdata;
        w_busy_n      = r_busy;
        w_done_n      = r_done;
        w_error_n     = r_error;
        w_last_read_n = r_last_read;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_ptr_n   = '0;
                    w_done_n  = 1'b0;
                    w_error_n = 1'b0;
                    w_busy_n  = 1'b1;
                    w_state_n = S_FETCH;
                end
            end
            S_FETCH: w_state_n = S_DECODE;
            S_DECODE: begin
                if (!script_data[15]) begin
                    w_addr_n  = script_data[14:8];
                    w_wdata_n = script_data[7:0];
                    w_write_n = 1'b1;
                    w_state_n = S_WRITE;
                end else begin
                    case (script_data[14:12])
                        c_OP_WAIT: begin
                            w_cnt_n   = script_data[11:0];
                            w_state_n = (script_data[11:0] == 12'd0) ? S_ADVANCE : S_WAIT;
                        end
                        c_OP_END: begin
                            w_done_n  = 1'b1;
                            w_busy_n  = 1'b0;
                            w_state_n = S_IDLE;
                        end
                        c_OP_READ: begin
                            w_addr_n  = script_data[6:0];
                            w_read_n  = 1'b1;
                            w_state_n = S_READ;
                        end
                        c_OP_LOOP: begin
                            w_ptr_n   = '0;
                            w_state_n = S_FETCH;
                        end
                        default: begin
                            w_error_n = 1'b1;
                            w_busy_n  = 1'b0;
                            w_state_n = S_IDLE;
                        end
                    endcase
                end
            end
            // Strobe is held until the sound block's ce accepts it
            S_WRITE: begin
                if (ce) begin
                    w_write_n = 1'b0;
                    w_state_n = S_ADVANCE;
                end
            end
            S_READ: begin
                if (ce) begin
                    w_last_read_n = s1_readdata;
                    w_read_n      = 1'b0;
                    w_state_n     = S_ADVANCE;
                end
            end
            S_WAIT: begin
                if (ce) begin
                    w_cnt_n = r_cnt - 12'd1;
                    if (r_cnt == 12'd1) begin
                        w_state_n = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                if (r_ptr == c_PTR_LAST) begin
                    w_error_n = 1'b1;
                    w_busy_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else begin
                    w_ptr_n   = r_ptr + ADDR_W'(1);
                    w_state_n = S_FETCH;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Abort overrides everything decoded this cycle except the sticky flags
        if (stop && (r_state != S_IDLE)) begin
            w_state_n = S_IDLE;
            w_read_n  = 1'b0;
            w_write_n = 1'b0;
            w_busy_n  = 1'b0;
            w_done_n  = r_done;
            w_error_n = r_error;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_last_read <= '0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_cnt       <= w_cnt_n;
            r_read      <= w_read_n;
            r_write     <= w_write_n;
            r_addr      <= w_addr_n;
            r_wdata     <= w_wdata_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_error     <= w_error_n;
            r_last_read <= w_last_read_n;
        end
    end

    assign script_addr  = r_ptr;
    assign s1_read      = r_read;
    assign s1_write     = r_write;
    assign s1_addr      = r_addr;
    assign s1_writedata = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign last_read    = r_last_read;

endmodule
`default_nettype wire

// File: tb/tb_gbc_snd_reg_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gbc_snd_reg_player
// Brief    : Scoreboard bench for the sound register script player.
// Revision : 1.0
// ============================================================================
module tb_gbc_snd_reg_player;

    logic        clk = 1'b0;
    logic        reset, ce, start, stop;
    logic [9:0]  script_addr;
    logic [15:0] script_data;
    logic        s1_read, s1_write;
    logic [6:0]  s1_addr;
    logic [7:0]  s1_writedata, s1_readdata;
    logic        busy, done, error;
    logic [7:0]  last_read;

    logic        start2, stop2;
    logic [1:0]  script_addr2;
    logic [15:0] script_data2;
    logic        s1_read2, s1_write2;
    logic [6:0]  s1_addr2;
    logic [7:0]  s1_writedata2, s1_readdata2;
    logic        busy2, done2, error2;
    logic [7:0]  last_read2;

    logic [15:0] mem  [0:1023];
    logic [15:0] mem2 [0:3];

    typedef struct {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t exp2_q[$];
    int    t_xfer[$];
    int    c_xfer[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    ce_period = 1;
    int    ce_count = 0;
    int    xfer_count = 0;
    int    wr2_count = 0;

    gbc_snd_reg_player dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .stop(stop),
        .script_addr(script_addr), .script_data(script_data),
        .s1_read(s1_read), .s1_write(s1_write), .s1_addr(s1_addr),
        .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .busy(busy), .done(done), .error(error), .last_read(last_read)
    );

    gbc_snd_reg_player #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .ce(ce), .start(start2), .stop(stop2),
        .script_addr(script_addr2), .script_data(script_data2),
        .s1_read(s1_read2), .s1_write(s1_write2), .s1_addr(s1_addr2),
        .s1_writedata(s1_writedata2), .s1_readdata(s1_readdata2),
        .busy(busy2), .done(done2), .error(error2), .last_read(last_read2)
    );

    always #5 clk = ~clk;

    // Synchronous script ROMs and a sound block whose register 0x26 reads 0xF0
    always @(posedge clk) script_data  <= mem[script_addr];
    always @(posedge clk) script_data2 <= mem2[script_addr2];
    assign s1_readdata  = {1'b0, s1_addr}  ^ 8'hD6;
    assign s1_readdata2 = {1'b0, s1_addr2} ^ 8'hD6;

    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ce = (ce_period <= 1) ? 1'b1 : ((cyc % ce_period) == 0);
        end
    end

    // Bus monitor: a transfer is a strobe seen together with ce
    logic        p_strobe, p_ce, p_xfer;
    logic [16:0] p_vec;
    always @(negedge clk) begin
        if (reset) begin
            p_strobe = 1'b0; p_ce = 1'b0; p_xfer = 1'b0; p_vec = '0;
        end else begin
            if (ce) ce_count++;
            n_checks++;
            if (s1_read && s1_write) $display("FAIL both_strobes got read=1 write=1 want not both");
            else n_pass++;
            if (p_strobe && !p_ce) begin
                n_checks++;
                if ({s1_read, s1_write, s1_addr, s1_writedata} !== p_vec)
                    $display("FAIL strobe_hold got %h want %h", {s1_read, s1_write, s1_addr, s1_writedata}, p_vec);
                else n_pass++;
            end
            if (p_xfer) begin
                n_checks++;
                if (s1_read || s1_write) $display("FAIL strobe_drop got read=%b write=%b want 0", s1_read, s1_write);
                else n_pass++;
            end
            if ((s1_read || s1_write) && ce) begin
                xfer_count++;
                t_xfer.push_back(cyc);
                c_xfer.push_back(ce_count);
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_xfer got rd=%b addr=%h data=%h want none", s1_read, s1_addr, s1_writedata);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    if (s1_read !== e.rd || s1_addr !== e.addr || (!e.rd && s1_writedata !== e.data))
                        $display("FAIL xfer got rd=%b addr=%h data=%h want rd=%b addr=%h data=%h",
                                 s1_read, s1_addr, s1_writedata, e.rd, e.addr, e.data);
                    else n_pass++;
                end
            end
            p_strobe = s1_read || s1_write;
            p_ce     = ce;
            p_xfer   = p_strobe && ce;
            p_vec    = {s1_read, s1_write, s1_addr, s1_writedata};
        end
    end

    always @(negedge clk) begin
        if (!reset && s1_write2 && ce) begin
            wr2_count++;
            n_checks++;
            if (exp2_q.size() == 0) begin
                $display("FAIL unexpected_xfer2 got addr=%h data=%h want none", s1_addr2, s1_writedata2);
            end else begin
                xfer_t e;
                e = exp2_q.pop_front();
                if (s1_addr2 !== e.addr || s1_writedata2 !== e.data)
                    $display("FAIL xfer2 got addr=%h data=%h want addr=%h data=%h", s1_addr2, s1_writedata2, e.addr, e.data);
                else n_pass++;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h9000;
        t_xfer.delete();
        c_xfer.delete();
    endtask

    task automatic push_exp(input logic rd, input logic [6:0] a, input logic [7:0] d);
        xfer_t e;
        e.rd = rd; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic run_script(input int max_cyc);
        bit finished;
        finished = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start got %b want 1", busy);
        else n_pass++;
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!finished) $display("FAIL script_timeout got busy=1 after %0d clk want busy=0", max_cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem2[i] = 16'h9000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s1_read, s1_write} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {s1_read, s1_write});
        else n_pass++;
        n_checks++;
        if ({s1_addr, s1_writedata, script_addr} !== 25'd0)
            $display("FAIL reset_bus got addr=%h data=%h saddr=%h want 0", s1_addr, s1_writedata, script_addr);
        else n_pass++;
        n_checks++;
        if ({busy, done, error, last_read} !== 11'd0)
            $display("FAIL reset_status got busy=%b done=%b error=%b last_read=%h want 0", busy, done, error, last_read);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_write_ce1();
        clear_mem();
        ce_period = 1;
        mem[0] = 16'h2680; mem[1] = 16'h1277; mem[2] = 16'h9000;
        push_exp(1'b0, 7'h26, 8'h80);
        push_exp(1'b0, 7'h12, 8'h77);
        run_script(200);
        n_checks++;
        if (exp_q.size() != 0 || t_xfer.size() != 2)
            $display("FAIL w1_count got %0d xfers with %0d pending want 2 xfers 0 pending", t_xfer.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (t_xfer.size() == 2 && (t_xfer[1] - t_xfer[0]) != 4)
            $display("FAIL w1_spacing got %0d clk want 4", t_xfer[1] - t_xfer[0]);
        else n_pass++;
        n_checks++;
        if ({done, busy, error} !== 3'b100) $display("FAIL w1_status got done=%b busy=%b error=%b want 1 0 0", done, busy, error);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_write_ce_sparse();
        clear_mem();
        ce_period = 4;
        mem[0] = 16'h2680; mem[1] = 16'h1277; mem[2] = 16'h9000;
        push_exp(1'b0, 7'h26, 8'h80);
        push_exp(1'b0, 7'h12, 8'h77);
        run_script(400);
        n_checks++;
        if (exp_q.size() != 0 || t_xfer.size() != 2)
            $display("FAIL w4_count got %0d xfers with %0d pending want 2 xfers 0 pending", t_xfer.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if ({done, busy, error} !== 3'b100) $display("FAIL w4_status got done=%b busy=%b error=%b want 1 0 0", done, busy, error);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_wait();
        int d_clk5, d_ce5, d_clk0, d_ce0;
        d_clk5 = 0; d_ce5 = 0; d_clk0 = 0; d_ce0 = 0;
        ce_period = 3;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem[0] = 16'h2011;
            mem[1] = (pass == 0) ? 16'h8005 : 16'h8000;
            mem[2] = 16'h2022;
            mem[3] = 16'h9000;
            push_exp(1'b0, 7'h20, 8'h11);
            push_exp(1'b0, 7'h20, 8'h22);
            run_script(600);
            n_checks++;
            if (t_xfer.size() != 2 || exp_q.size() != 0) begin
                $display("FAIL wait_count got %0d xfers with %0d pending want 2 xfers 0 pending", t_xfer.size(), exp_q.size());
            end else begin
                n_pass++;
                if (pass == 0) begin d_clk5 = t_xfer[1] - t_xfer[0]; d_ce5 = c_xfer[1] - c_xfer[0]; end
                else           begin d_clk0 = t_xfer[1] - t_xfer[0]; d_ce0 = c_xfer[1] - c_xfer[0]; end
            end
            exp_q.delete();
        end
        n_checks++;
        if (d_clk5 != 24) $display("FAIL wait5_clk got %0d want 24", d_clk5);
        else n_pass++;
        n_checks++;
        if (d_clk0 != 9) $display("FAIL wait0_clk got %0d want 9", d_clk0);
        else n_pass++;
        n_checks++;
        if ((d_ce5 - d_ce0) != 5) $display("FAIL wait_ce_pulses got %0d want 5", d_ce5 - d_ce0);
        else n_pass++;
        ce_period = 1;
    endtask

    task automatic test_read();
        clear_mem();
        ce_period = 1;
        mem[0] = 16'hA026; mem[1] = 16'h9000;
        push_exp(1'b1, 7'h26, 8'h00);
        run_script(200);
        n_checks++;
        if (exp_q.size() != 0 || t_xfer.size() != 1)
            $display("FAIL rd_count got %0d xfers with %0d pending want 1 xfer 0 pending", t_xfer.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (last_read !== 8'hF0) $display("FAIL rd_data got %h want f0", last_read);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_loop_stop();
        bit seen;
        seen = 1'b0;
        clear_mem();
        mem[0] = 16'h2155; mem[1] = 16'hB000;
        for (int i = 0; i < 3; i++) push_exp(1'b0, 7'h21, 8'h55);
        xfer_count = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (xfer_count >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL loop_timeout got %0d writes want 3", xfer_count);
        else n_pass++;
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        n_checks++;
        if ({s1_read, s1_write, busy, done} !== 4'b0000)
            $display("FAIL stop_state got read=%b write=%b busy=%b done=%b want 0 0 0 0", s1_read, s1_write, busy, done);
        else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (xfer_count != 3 || exp_q.size() != 0)
            $display("FAIL loop_writes got %0d writes with %0d pending want 3 and 0", xfer_count, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = 16'hC000;
        xfer_count = 0;
        run_script(100);
        n_checks++;
        if ({error, done, busy} !== 3'b100 || xfer_count != 0)
            $display("FAIL illegal got error=%b done=%b busy=%b xfers=%0d want 1 0 0 0", error, done, busy, xfer_count);
        else n_pass++;
    endtask

    task automatic test_start_stop_same();
        clear_mem();
        mem[0] = 16'h2033;
        xfer_count = 0;
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || xfer_count != 0)
            $display("FAIL start_stop got busy=%b xfers=%0d want 0 0", busy, xfer_count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer_t e;
            mem2[i] = {1'b0, 7'(i + 1), 8'(16 * i + 5)};
            e.rd = 1'b0; e.addr = 7'(i + 1); e.data = 8'(16 * i + 5);
            exp2_q.push_back(e);
        end
        wr2_count = 0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy2) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!finished) $display("FAIL ovf_timeout got busy2=1 want 0");
        else n_pass++;
        n_checks++;
        if (wr2_count != 4 || exp2_q.size() != 0)
            $display("FAIL ovf_writes got %0d with %0d pending want 4 and 0", wr2_count, exp2_q.size());
        else n_pass++;
        n_checks++;
        if ({error2, busy2, done2, s1_read2} !== 4'b1000 || last_read2 !== 8'h00)
            $display("FAIL ovf_status got error=%b busy=%b done=%b read=%b last=%h want 1 0 0 0 00",
                     error2, busy2, done2, s1_read2, last_read2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_ce1();
        test_write_ce_sparse();
        test_wait();
        test_read();
        test_loop_stop();
        test_illegal();
        test_start_stop_same();
        test_overflow();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
